// File: rtl/symm_gram_seq.sv
// Sequential Gram-matrix engine: G = A*A^T in signed fixed point, one MAC per enabled cycle.
// Only the upper triangle is computed; each result is mirrored into both symmetric slots.
//
//   state | meaning
//   IDLE  | waiting for start, outputs hold
//   CALC  | walking (i, j>=i, k) and accumulating A[i][k]*A[j][k]
//   DONE  | gram_out valid, done pulses for one enabled cycle
module symm_gram_seq #(
  parameter int N    = 4,
  parameter int DW   = 26,
  parameter int FRAC = 13,
  parameter int SAT  = 1
) (
  input  logic                clk_gram,
  input  logic                rst_gram,
  input  logic                en_gram,
  input  logic                start,
  input  logic [N*N*DW-1:0]   in_mat,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [N*N*DW-1:0]   mat_out,
  output logic [N*N*DW-1:0]   gram_out
);

  localparam int AW = 2*DW + $clog2(N);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N-1);
  localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state;
  logic signed [DW-1:0]   a       [N][N];
  logic signed [DW-1:0]   res     [N][N];
  logic signed [DW-1:0]   res_nxt [N][N];
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   sum;
  logic signed [AW-1:0]   shifted;
  logic signed [2*DW-1:0] prod;
  logic signed [DW-1:0]   scaled;
  logic                   clamp;
  logic [CW-1:0]          i, j, k;
  logic                   last_k;
  logic                   last_entry;

  assign last_k     = (k == LAST);
  assign last_entry = last_k && (i == LAST) && (j == LAST);

  always_comb begin
    prod    = (2*DW)'(a[i][k]) * (2*DW)'(a[j][k]);
    sum     = acc + AW'(prod);
    shifted = sum >>> FRAC;
    clamp   = 1'b0;
    scaled  = sum[FRAC+DW-1:FRAC];
    if (SAT != 0) begin
      if (shifted > SMAX) begin
        scaled = {1'b0, {(DW-1){1'b1}}};
        clamp  = 1'b1;
      end else if (shifted < SMIN) begin
        scaled = {1'b1, {(DW-1){1'b0}}};
        clamp  = 1'b1;
      end
    end
    res_nxt       = res;
    res_nxt[i][j] = scaled;
    res_nxt[j][i] = scaled;
  end

  always_ff @(posedge clk_gram or posedge rst_gram) begin
    if (rst_gram) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      mat_out  <= '0;
      gram_out <= '0;
      acc      <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a[r][c]   <= '0;
          res[r][c] <= '0;
        end
      end
    end else if (en_gram) begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                a[r][c] <= in_mat[(r*N+c)*DW +: DW];
              end
            end
            mat_out <= in_mat;
            ovf     <= 1'b0;
            acc     <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (last_k) begin
            res <= res_nxt;
            acc <= '0;
            k   <= '0;
            if (clamp) ovf <= 1'b1;
            if (j == LAST) begin
              i <= i + 1'b1;
              j <= i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
            // Publish the whole matrix at once, including the entry finishing now.
            if (last_entry) begin
              for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                  gram_out[(r*N+c)*DW +: DW] <= res_nxt[r][c];
                end
              end
              i     <= '0;
              j     <= '0;
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            acc <= sum;
            k   <= k + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/symm_gram_seq.md
SYMM_GRAM_SEQ -- requirements
Module: symm_gram_seq

Interface
REQ-001 Parameter N, default 4, matrix dimension (N x N), legal 2..8.
REQ-002 Parameter DW, default 26, signed element width.
REQ-003 Parameter FRAC, default 13, fractional bits of the fixed-point format.
REQ-004 Parameter SAT, default 1: 1 = saturate results, 0 = truncate.
REQ-005 clk_gram  input  1  single clock; all logic on its rising edge.
REQ-006 rst_gram  input  1  reset, asynchronous, active-high.
REQ-007 en_gram  input  1  clock enable; low freezes all state.
REQ-008 start  input  1  request; sampled only in IDLE with en_gram=1.
REQ-009 in_mat  input  N*N*DW  element (r,c) at bits [(r*N+c)*DW +: DW], signed.
REQ-010 busy  output  1  high in CALC and DONE.
REQ-011 done  output  1  high for exactly one enabled cycle when results are valid.
REQ-012 ovf  output  1  sticky: saturation occurred in the current/last computation.
REQ-013 mat_out  output  N*N*DW  registered copy of in_mat captured at start.
REQ-014 gram_out  output  N*N*DW  result G = A*A^T, same packing as in_mat.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE; after reset it is in IDLE.
REQ-016 IDLE with start=1 and en_gram=1: capture in_mat into the working matrix and into mat_out, clear ovf, clear accumulator, set i=j=k=0, go to CALC.
REQ-017 CALC: one MAC per enabled cycle, acc += A[i][k]*A[j][k], signed; accumulator width 2*DW+ceil(log2 N).
REQ-018 The block SHALL compute only the upper triangle (i<=j), order i-major, j from i to N-1; each entry takes N cycles (k=0..N-1).
REQ-019 On k=N-1 the final sum (acc plus current product) SHALL be scaled by arithmetic shift right FRAC and stored to both result slots (i,j) and (j,i); the accumulator then restarts at 0.
REQ-020 Scaling with SAT=1: values above 2^(DW-1)-1 or below -2^(DW-1) clamp to those limits and set ovf. With SAT=0: keep bits [FRAC+DW-1:FRAC] of the exact sum; ovf stays 0.
REQ-021 After the entry (N-1,N-1) completes, go to DONE. CALC SHALL last exactly N*N*(N+1)/2 enabled cycles (40 for N=4).
REQ-022 gram_out SHALL update atomically on the edge entering DONE and hold until the next DONE.
REQ-023 DONE: done=1 for one enabled cycle, then go to IDLE. With default parameters and en_gram held high, done is high in the 41st cycle after the start-sampling edge.
REQ-024 start while busy=1 SHALL be ignored: no restart, no queueing.
REQ-025 en_gram=0 SHALL hold FSM, counters, accumulator and all outputs, including a pending done, which stays high until en_gram returns.
REQ-026 mat_out SHALL change only on start acceptance.

Reset
REQ-027 rst_gram=1 SHALL immediately force IDLE and zero busy, done, ovf, mat_out, gram_out, the accumulator and all counters, including mid-computation; no done is issued for an aborted run.
REQ-028 After rst_gram is released, the first start SHALL be accepted normally.

Verification
REQ-029 Identity: diagonal entries 8192 (1.0 Q13), others 0, default parameters -> gram_out diagonal 8192, off-diagonal 0; done at cycle 41; mat_out equals the input.
REQ-030 Sign and symmetry: row0 all -8192, row1 all 8192, other rows 0 -> G[0][0]=G[1][1]=32768, G[0][1]=G[1][0]=-32768, all others 0, ovf=0.
REQ-031 Saturation: all entries 2^25-1. SAT=1 -> every G entry 2^25-1 and ovf=1. SAT=0 -> every entry equals bits [38:13] of 4*(2^25-1)^2, ovf=0.
REQ-032 Stall/ignore: drop en_gram for 5 cycles mid-CALC and pulse start at cycle 10 -> done at cycle 46, results as in REQ-029, no second run.
REQ-033 Reset mid-op: assert rst_gram at cycle 20 of a run -> all outputs 0 immediately, no done; a subsequent identity run passes REQ-029.
